chip8_rom_loader: RTL
=====================

Name: chip8_rom_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch path; streams a program image into the 4 KiB CHIP-8 memory starting at the program base (0x200).
- Accepts a byte stream (valid/ready) carrying a 2-byte big-endian length header followed by payload bytes, and issues one memory write per payload byte.
- Holds the CPU in reset via cpu_hold until a load completes cleanly.

Parameters:
- ADDR_W, 12, memory address width (4096 bytes).
- LOAD_BASE, 12'h200, address of the first payload byte.
- MEM_SIZE, 4096, total memory bytes; maximum payload is MEM_SIZE-LOAD_BASE (3584).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  8  memory write data.
- cpu_hold  out  1  drives the CPU rst; 1 = CPU held.
- done  out  1  load completed successfully (level).
- error  out  1  load aborted (level).

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, length=0, count=0.
- Accept: a byte is accepted on a rising edge where in_valid and in_ready are both 1. in_ready is combinational from state: it is 1 only in LEN_HI, LEN_LO and DATA (and CSUM when enabled).
- States and transitions:
  - IDLE: on start go to LEN_HI, with cpu_hold=1, done=0, error=0.
  - LEN_HI: on accept, length[15:8]=in_data; go to LEN_LO.
  - LEN_LO: on accept, length[7:0]=in_data and count=0.
    - If the full length is 0: go to DONE (or CSUM when enabled).
    - If the length exceeds MEM_SIZE-LOAD_BASE: go to ERR.
    - Otherwise: go to DATA.
  - DATA: on accept, register mem_we=1, mem_addr=LOAD_BASE+count (ADDR_W bits) and mem_wdata=in_data.
    - The write is therefore visible one cycle after the accepting edge; mem_we stays high for exactly one cycle per byte.
    - Back-to-back accepts give back-to-back writes with no bubble.
    - count increments; when count+1==length, go to DONE (or CSUM).
  - DONE: done=1, cpu_hold=0, in_ready=0. The final mem_we pulse and the assertion of done occur on the same cycle. Stay in DONE until start.
  - ERR: error=1, cpu_hold=1, in_ready=0. No further writes. Stay in ERR until start.
- start while in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- Restarting from DONE or ERR reasserts cpu_hold on the next edge and clears done and error.
- Address never wraps: the length check guarantees LOAD_BASE+length-1 <= MEM_SIZE-1.
- Bytes outside the accept window are ignored, and in_data is don't-care when in_valid=0.
- rst mid-load:
  - Returns to IDLE on that edge; mem_we=0 from that edge on.
  - Bytes already written stay in memory.
  - cpu_hold=1 after reset.
- rst has priority over start on the same edge.

Optional Feature:
- Macro: CHIP8_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte (or directly after a zero length), state CSUM accepts one trailing byte.
  - An 8-bit running sum covers all payload bytes. If (sum + trailing byte) mod 256 == 0, go to DONE; otherwise go to ERR.
  - Payload bytes are already written to memory before a checksum failure is detected; cpu_hold remains 1 in ERR.
- Undefined:
  - No CSUM state and no trailing byte.
  - DATA goes to DONE directly, and a zero length goes straight to DONE.

Test Plan:
- Reset then start; stream 00 04 12 34 A2 F0 with in_valid held high:
  - Writes 0x200=12, 0x201=34, 0x202=A2, 0x203=F0 on four consecutive cycles.
  - done=1 and cpu_hold=0 on the cycle of the last write.
- Same stream with in_valid toggled 1/0 each cycle: the same four writes occur, each one cycle after its accept, with no extra mem_we pulses.
- Length header 0E 01 (3585): go to ERR, error=1, cpu_hold=1, no mem_we. Then start plus header 00 00: done=1, error=0.
- Assert rst after the second payload byte of a 4-byte load: state is IDLE, cpu_hold=1, done=0, and no further writes. A fresh start then reloads correctly from 0x200.
- Header 0D FF (3583) followed by 3583 bytes: the last write goes to address 0xFFE and done=1. Header 0E 00 (3584): the last write goes to 0xFFF, no wrap.
- With CHIP8_LOADER_CHECKSUM_EN: payload 01 02 03 with checksum FA gives done=1. The same payload with checksum FB gives error=1 and cpu_hold=1, with three writes already performed.

Source files
------------

// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader
//   Streams a CHIP-8 program image into the 4 KiB memory starting at LOAD_BASE.
//   Input is a byte stream: a 2-byte big-endian length header, then the payload.
//   Each payload byte produces one registered memory write. While a load is in
//   progress, or after it aborts, the CPU is held in reset.
//
//   Optional build macro: CHIP8_LOADER_CHECKSUM_EN
//     When defined, one trailing checksum byte follows the payload. The load
//     succeeds only if (sum of payload bytes + checksum byte) mod 256 == 0.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_i      single-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid_i   input byte valid
//   in_data_i    input byte
//   in_ready_o   loader accepts a byte this cycle
//   mem_we_o     memory write strobe (one cycle per payload byte)
//   mem_addr_o   memory write address
//   mem_wdata_o  memory write data
//   cpu_hold_o   CPU reset, 1 = CPU held
//   done_o       load completed successfully (level)
//   error_o      load aborted (level)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | waiting for length header high byte
// LEN_LO | waiting for length header low byte, length is checked here
// DATA   | accepting payload bytes, one write each
// CSUM   | waiting for trailing checksum byte (checksum build only)
// DONE   | load finished, CPU released
// ERR    | load aborted, CPU held

module chip8_rom_loader #(
   parameter int                ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] LOAD_BASE = 12'h200,
   parameter int                MEM_SIZE  = 4096
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              error_o
);

   localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE - int'(LOAD_BASE));

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
`ifdef CHIP8_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              accept;
   logic [15:0]       len_full;
   logic [15:0]       cnt_next;
   // Where a finished payload goes: straight to DONE, or via the checksum byte.
   state_t            end_state;

`ifdef CHIP8_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        csum_total;
   assign end_state  = S_CSUM;
   assign csum_total = sum_q + in_data_i;
`else
   assign end_state  = S_DONE;
`endif

   always_comb begin
      in_ready_o = 1'b0;
      case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA: in_ready_o = 1'b1;
`ifdef CHIP8_LOADER_CHECKSUM_EN
         S_CSUM:                     in_ready_o = 1'b1;
`endif
         default:                    in_ready_o = 1'b0;
      endcase
   end

   assign accept   = in_valid_i && in_ready_o;
   assign len_full = {len_q[15:8], in_data_i};
   assign cnt_next = {{(16-ADDR_W){1'b0}}, cnt_q} + 16'd1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef CHIP8_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data_i;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data_i;
               cnt_d      = '0;
`ifdef CHIP8_LOADER_CHECKSUM_EN
               sum_d      = 8'h00;
`endif
               if (len_full == 16'd0)        state_d = end_state;
               else if (len_full > MAX_LEN)  state_d = S_ERR;
               else                          state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = LOAD_BASE + cnt_q;
               wdata_d = in_data_i;
               cnt_d   = cnt_q + 1'b1;
`ifdef CHIP8_LOADER_CHECKSUM_EN
               sum_d   = sum_q + in_data_i;
`endif
               if (cnt_next == len_q) state_d = end_state;
            end
         end
`ifdef CHIP8_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               if (csum_total == 8'h00) state_d = S_DONE;
               else                     state_d = S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 8'h00;
`ifdef CHIP8_LOADER_CHECKSUM_EN
         sum_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef CHIP8_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   // The final write and DONE are registered on the same edge, so done_o
   // rises together with the last mem_we_o pulse.
   assign done_o      = (state_q == S_DONE);
   assign error_o     = (state_q == S_ERR);
   assign cpu_hold_o  = (state_q != S_DONE);

endmodule
